// File: rtl/coef_bank_loader_pkg.sv
// Shared coefficient-path defaults (also used by the FIFO and the FIR) and loader state encoding.
package coef_bank_loader_pkg;

  localparam int COEF_W_DEF   = 16;
  localparam int NUM_TAPS_DEF = 128;
  localparam int ADDR_W_DEF   = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PEND = 2'd2
  } state_e;

endpackage

// File: rtl/coef_bank_ram.sv
// Simple dual-port coefficient store holding both banks; one write port, registered read port.
// Read latency 1 cycle; no reset on the array, the caller gates stale contents.
module coef_bank_ram
  import coef_bank_loader_pkg::*;
#(
  parameter int DATA_W = COEF_W_DEF,
  parameter int AW     = ADDR_W_DEF + 1
) (
  input  logic              clock,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**AW];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/coef_bank_loader.sv
// Loads NUM_TAPS coefficients from a non-showahead FIFO into the shadow bank, swaps on sample_tick.
// Coefficient read latency 1 cycle; FIFO empty stalls the load indefinitely, abort discards it.
module coef_bank_loader
  import coef_bank_loader_pkg::*;
#(
  parameter int COEF_W   = COEF_W_DEF,
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              sample_tick,
  input  logic              fifo_empty,
  output logic              fifo_read,
  input  logic [COEF_W-1:0] fifo_readdata,
  input  logic [ADDR_W-1:0] coef_rd_addr,
  output logic [COEF_W-1:0] coef_rd_data,
  output logic              busy,
  output logic              swap_pending,
  output logic              bank_sel,
  output logic              load_done
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] TAPS_C  = CNT_W'(NUM_TAPS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  written_q, written_d;
  logic              rd_vld_q;
  logic              bank_sel_q, bank_sel_d;
  logic [1:0]        bank_vld_q, bank_vld_d;
  logic              rd_ok_q;
  logic              wr_en;
  logic [COEF_W-1:0] ram_rd_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      issued_q   <= '0;
      written_q  <= '0;
      rd_vld_q   <= 1'b0;
      bank_sel_q <= 1'b0;
      bank_vld_q <= 2'b00;
      rd_ok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      written_q  <= written_d;
      rd_vld_q   <= fifo_read;
      bank_sel_q <= bank_sel_d;
      bank_vld_q <= bank_vld_d;
      rd_ok_q    <= bank_vld_q[bank_sel_q] && ({1'b0, coef_rd_addr} < TAPS_C);
    end
  end

  // Writes only land while still loading, so a word returning after abort is dropped.
  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    written_d  = written_q;
    bank_sel_d = bank_sel_q;
    bank_vld_d = bank_vld_q;
    fifo_read  = 1'b0;
    wr_en      = 1'b0;
    load_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d   = ST_LOAD;
          issued_d  = '0;
          written_d = '0;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          fifo_read = !fifo_empty && (issued_q < TAPS_C);
          if (fifo_read) begin
            issued_d = issued_q + CNT_ONE;
          end
          if (rd_vld_q) begin
            wr_en     = 1'b1;
            written_d = written_q + CNT_ONE;
          end
          if (written_q == TAPS_C) begin
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (sample_tick) begin
          load_done  = 1'b1;
          bank_sel_d = ~bank_sel_q;
          bank_vld_d = bank_vld_q | (bank_sel_q ? 2'b01 : 2'b10);
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  coef_bank_ram #(
    .DATA_W (COEF_W),
    .AW     (ADDR_W + 1)
  ) u_ram (
    .clock     (clock),
    .wr_en_i   (wr_en),
    .wr_addr_i ({~bank_sel_q, written_q[ADDR_W-1:0]}),
    .wr_data_i (fifo_readdata),
    .rd_addr_i ({bank_sel_q, coef_rd_addr}),
    .rd_data_o (ram_rd_data)
  );

  assign coef_rd_data = rd_ok_q ? ram_rd_data : '0;
  assign busy         = (state_q != ST_IDLE);
  assign swap_pending = (state_q == ST_PEND);
  assign bank_sel     = bank_sel_q;

endmodule

// File: tb/tb_coef_bank_loader.sv
// Scoreboard bench for coef_bank_loader with a behavioural non-showahead FIFO.
module tb_coef_bank_loader;

  localparam int CW = 16;
  localparam int NT = 128;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start, abort, sample_tick, fifo_empty;
  logic          fifo_read;
  logic [CW-1:0] fifo_readdata;
  logic [AW-1:0] coef_rd_addr;
  logic [CW-1:0] coef_rd_data;
  logic          busy, swap_pending, bank_sel, load_done;

  always #5 clock = ~clock;

  coef_bank_loader #(.COEF_W(CW), .NUM_TAPS(NT), .ADDR_W(AW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .sample_tick   (sample_tick),
    .fifo_empty    (fifo_empty),
    .fifo_read     (fifo_read),
    .fifo_readdata (fifo_readdata),
    .coef_rd_addr  (coef_rd_addr),
    .coef_rd_data  (coef_rd_data),
    .busy          (busy),
    .swap_pending  (swap_pending),
    .bank_sel      (bank_sel),
    .load_done     (load_done)
  );

  logic [CW-1:0] fifo_q [$];
  logic [CW-1:0] exp_q  [$];
  logic [CW-1:0] act_m  [NT];
  logic [CW-1:0] new_m  [NT];
  int n_cmp = 0, n_err = 0;
  int n_reads = 0, n_done = 0, cyc = 0, first_rd = 0, last_rd = 0;
  logic exp_bs;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: sample outputs mid-cycle, then apply FIFO response and clear pulses after the edge.
  task automatic tick();
    logic rd_seen;
    @(negedge clock);
    rd_seen = fifo_read;
    if (fifo_read) begin
      n_reads++;
      if (n_reads == 1) first_rd = cyc;
      last_rd = cyc;
    end
    if (load_done) n_done++;
    @(posedge clock);
    cyc++;
    #1;
    if (rd_seen && fifo_q.size() > 0) fifo_readdata = fifo_q.pop_front();
    fifo_empty  = (fifo_q.size() == 0);
    start       = 1'b0;
    abort       = 1'b0;
    sample_tick = 1'b0;
  endtask

  function automatic logic [CW-1:0] word(input int seed, input int k);
    return CW'(seed * 32'h1111 + k * 3);
  endfunction

  task automatic fill(input int seed, input int n, input int k0);
    for (int k = 0; k < n; k++) fifo_q.push_back(word(seed, k0 + k));
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic stage(input int seed);
    for (int k = 0; k < NT; k++) new_m[k] = word(seed, k);
  endtask

  task automatic go();
    n_reads = 0;
    start = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [CW-1:0] e, input string tag);
    coef_rd_addr = a;
    exp_q.push_back(e);
    tick();
    chk(tag, 32'(coef_rd_data), 32'(exp_q.pop_front()));
  endtask

  task automatic rd_all(input string tag);
    for (int a = 0; a < NT; a++) rd(AW'(a), act_m[a], tag);
  endtask

  task automatic wait_reads(input int n, input string tag);
    int i = 0;
    while (n_reads < n && i < 2000) begin tick(); i++; end
    if (n_reads < n) chk({tag, "_timeout"}, 32'(n_reads), 32'(n));
  endtask

  task automatic wait_pend(input string tag);
    int i = 0;
    while (!swap_pending && i < 2000) begin tick(); i++; end
    if (!swap_pending) chk({tag, "_timeout"}, 32'(swap_pending), 32'd1);
  endtask

  task automatic swap(input string tag);
    int d0 = n_done;
    sample_tick = 1'b1;
    tick();
    chk({tag, "_done"}, 32'(n_done - d0), 32'd1);
    for (int k = 0; k < NT; k++) act_m[k] = new_m[k];
    exp_bs = ~exp_bs;
    chk({tag, "_bank_sel"}, 32'(bank_sel), 32'(exp_bs));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; sample_tick = 1'b0;
    fifo_empty = 1'b1; fifo_readdata = '0; coef_rd_addr = '0; exp_bs = 1'b0;
    for (int k = 0; k < NT; k++) act_m[k] = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rd_data", 32'(coef_rd_data), 32'd0);
    chk("rst_bank_sel", 32'(bank_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pend", 32'(swap_pending), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_fifo_read", 32'(fifo_read), 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: both banks invalid after reset
    rd_all("t1_zero");

    // 2: full back-to-back load of k*3, then swap
    fill(0, NT, 0); stage(0); go();
    wait_pend("t2_pend");
    chk("t2_reads", 32'(n_reads), 32'(NT));
    chk("t2_b2b", 32'(last_rd - first_rd), 32'(NT - 1));
    chk("t2_pending", 32'(swap_pending), 32'd1);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_bs_before", 32'(bank_sel), 32'd0);
    swap("t2_swap");
    rd(AW'(5), 16'd15, "t2_addr5");
    rd_all("t2_data");

    // 3: FIFO runs dry for 20 cycles mid-load
    fill(2, 50, 0); stage(2); go();
    wait_reads(50, "t3_first");
    repeat (20) tick();
    chk("t3_stall_reads", 32'(n_reads), 32'd50);
    chk("t3_stall_busy", 32'(busy), 32'd1);
    chk("t3_stall_pend", 32'(swap_pending), 32'd0);
    fill(2, NT - 50, 50);
    wait_pend("t3_pend");
    chk("t3_reads", 32'(n_reads), 32'(NT));
    swap("t3_swap");
    rd_all("t3_data");

    // 4: abort after 60 words keeps the old bank, then a fresh load
    fill(4, NT, 0); go();
    wait_reads(60, "t4_60");
    abort = 1'b1;
    tick();
    fifo_q.delete(); fifo_empty = 1'b1;
    chk("t4_abort_reads", 32'(n_reads), 32'd60);
    chk("t4_abort_busy", 32'(busy), 32'd0);
    chk("t4_abort_bs", 32'(bank_sel), 32'(exp_bs));
    repeat (3) tick();
    rd_all("t4_old");
    fill(6, NT, 0); stage(6); go();
    wait_pend("t4_pend");
    chk("t4_reads", 32'(n_reads), 32'(NT));
    swap("t4_swap");
    rd_all("t4_new");

    // 5: tick on the final-write cycle does nothing; swap-cycle read sees old bank
    fill(5, NT, 0); stage(5); go();
    wait_reads(NT, "t5_reads");
    d0 = n_done;
    sample_tick = 1'b1;
    tick();
    chk("t5_early_done", 32'(n_done - d0), 32'd0);
    chk("t5_early_bs", 32'(bank_sel), 32'(exp_bs));
    wait_pend("t5_pend");
    coef_rd_addr = '0;
    exp_q.push_back(act_m[0]);
    sample_tick = 1'b1;
    d0 = n_done;
    tick();
    chk("t5_swap_done", 32'(n_done - d0), 32'd1);
    chk("t5_swap_old", 32'(coef_rd_data), 32'(exp_q.pop_front()));
    for (int k = 0; k < NT; k++) act_m[k] = new_m[k];
    exp_bs = ~exp_bs;
    chk("t5_bs", 32'(bank_sel), 32'(exp_bs));
    rd(AW'(0), act_m[0], "t5_new0");

    // 6: start during LOAD ignored; out-of-range addresses read 0
    fill(7, NT + 10, 0); stage(7); go();
    repeat (5) tick();
    start = 1'b1; tick();
    repeat (30) tick();
    start = 1'b1; tick();
    wait_pend("t6_pend");
    repeat (10) tick();
    chk("t6_reads", 32'(n_reads), 32'(NT));
    chk("t6_still_pend", 32'(swap_pending), 32'd1);
    fifo_q.delete(); fifo_empty = 1'b1;
    swap("t6_swap");
    rd_all("t6_data");
    rd(AW'(200), '0, "t6_addr200");
    rd(AW'(128), '0, "t6_addr128");
    rd(AW'(255), '0, "t6_addr255");

    // abort while pending: no swap, later tick ignored
    fill(8, NT, 0); go();
    wait_pend("t7_pend");
    abort = 1'b1; tick();
    chk("t7_abort_busy", 32'(busy), 32'd0);
    d0 = n_done;
    sample_tick = 1'b1; tick();
    chk("t7_tick_done", 32'(n_done - d0), 32'd0);
    chk("t7_bs", 32'(bank_sel), 32'(exp_bs));
    rd(AW'(3), act_m[3], "t7_old3");

    // reset mid-load: active bank reads 0 again
    fill(9, NT, 0); go();
    repeat (10) tick();
    reset_n = 1'b0;
    #20;
    chk("t8_rst_busy", 32'(busy), 32'd0);
    chk("t8_rst_bs", 32'(bank_sel), 32'd0);
    fifo_q.delete(); fifo_empty = 1'b1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    exp_bs = 1'b0;
    for (int k = 0; k < NT; k++) act_m[k] = '0;
    tick();
    rd(AW'(0), '0, "t8_zero0");
    rd(AW'(5), '0, "t8_zero5");
    rd(AW'(127), '0, "t8_zero127");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
